// File: rtl/assoc_cache_controller.sv
// 2-way set-associative write-back/write-allocate cache controller with per-set LRU.
// Define CACHE_STATS_EN to add saturating hit/miss/writeback counters.
module assoc_cache_controller #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_rw,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [WORD_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [WORD_W-1:0] cpu_resp_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs
`endif
);

    localparam int unsigned OFF_W   = $clog2(LINE_W / 8);
    localparam int unsigned WSEL_LO = $clog2(WORD_W / 8);
    localparam int unsigned WSEL_W  = OFF_W - WSEL_LO;
    localparam int unsigned TAG_W   = ADDR_W - OFF_W - INDEX_W;
    localparam int unsigned SETS    = 2 ** INDEX_W;

    typedef enum logic [2:0] {StIdle, StCompare, StWriteback, StAllocate, StRefill} state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    req_tag_q;
    logic [INDEX_W-1:0]  req_idx_q;
    logic [WSEL_W-1:0]   req_wsel_q;
    logic                req_rw_q;
    logic [WORD_W-1:0]   req_wdata_q;
    logic                victim_q, victim_d;
    logic                first_q;
    logic                resp_valid_q;
    logic [WORD_W-1:0]   resp_rdata_q;

    logic [TAG_W-1:0]    tag_arr  [2][SETS];
    logic [LINE_W-1:0]   data_arr [2][SETS];
    logic [SETS-1:0]     valid_q  [2];
    logic [SETS-1:0]     dirty_q  [2];
    logic [SETS-1:0]     lru_q;

    logic                hit0, hit1, hit, hit_way, miss_victim;
    logic                hit_we, fill_we, accept;
    logic [LINE_W-1:0]   hit_line, merged_line;
    logic [WORD_W-1:0]   rd_word;
    int unsigned         word_lo;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_req_addr[WSEL_LO-1:0];

    assign cpu_req_ready  = (state_q == StIdle);
    assign accept         = cpu_req_valid && cpu_req_ready;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;

    assign hit0     = valid_q[0][req_idx_q] && (tag_arr[0][req_idx_q] == req_tag_q);
    assign hit1     = valid_q[1][req_idx_q] && (tag_arr[1][req_idx_q] == req_tag_q);
    assign hit      = hit0 || hit1;
    assign hit_way  = ~hit0;
    assign hit_line = data_arr[hit_way][req_idx_q];
    assign word_lo  = WORD_W * 32'(req_wsel_q);
    assign rd_word  = hit_line[word_lo +: WORD_W];

    // Prefer an empty way; only fall back to LRU when the set is full.
    assign miss_victim = !valid_q[0][req_idx_q] ? 1'b0 :
                         !valid_q[1][req_idx_q] ? 1'b1 : lru_q[req_idx_q];

    always_comb begin
        merged_line = hit_line;
        merged_line[word_lo +: WORD_W] = req_wdata_q;
    end

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        hit_we        = 1'b0;
        fill_we       = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StCompare;
            end
            StCompare: begin
                if (hit) begin
                    hit_we  = req_rw_q;
                    state_d = StIdle;
                end else begin
                    victim_d = miss_victim;
                    state_d  = (valid_q[miss_victim][req_idx_q] && dirty_q[miss_victim][req_idx_q])
                               ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {tag_arr[victim_q][req_idx_q], req_idx_q, {OFF_W{1'b0}}};
                mem_req_wdata = data_arr[victim_q][req_idx_q];
                if (mem_req_ready) state_d = StAllocate;
            end
            StAllocate: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                if (mem_req_ready) state_d = StRefill;
            end
            StRefill: begin
                if (mem_resp_valid) begin
                    fill_we = 1'b1;
                    state_d = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_wsel_q   <= '0;
            req_rw_q     <= 1'b0;
            req_wdata_q  <= '0;
            victim_q     <= 1'b0;
            first_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            dirty_q[0]   <= '0;
            dirty_q[1]   <= '0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            resp_valid_q <= 1'b0;
            if (accept) begin
                req_tag_q   <= cpu_req_addr[ADDR_W-1:OFF_W+INDEX_W];
                req_idx_q   <= cpu_req_addr[OFF_W+INDEX_W-1:OFF_W];
                req_wsel_q  <= cpu_req_addr[OFF_W-1:WSEL_LO];
                req_rw_q    <= cpu_req_rw;
                req_wdata_q <= cpu_req_wdata;
                first_q     <= 1'b1;
            end
            if (state_q == StCompare) begin
                first_q <= 1'b0;
                if (hit) begin
                    resp_valid_q     <= 1'b1;
                    lru_q[req_idx_q] <= ~hit_way;
                    if (req_rw_q) dirty_q[hit_way][req_idx_q] <= 1'b1;
                    else          resp_rdata_q                <= rd_word;
                end
            end
            if (fill_we) begin
                valid_q[victim_q][req_idx_q] <= 1'b1;
                dirty_q[victim_q][req_idx_q] <= 1'b0;
            end
        end
    end

    // Tag/data storage is left unreset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (hit_we) data_arr[hit_way][req_idx_q] <= merged_line;
        if (fill_we) begin
            data_arr[victim_q][req_idx_q] <= mem_resp_rdata;
            tag_arr[victim_q][req_idx_q]  <= req_tag_q;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, misses_q, wbs_q;
    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
    assign stat_wbs    = wbs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            if (state_q == StCompare && first_q && hit && hits_q != '1) hits_q <= hits_q + 32'd1;
            if (state_q == StCompare && first_q && !hit && misses_q != '1) begin
                misses_q <= misses_q + 32'd1;
            end
            if (state_q == StWriteback && mem_req_ready && wbs_q != '1) wbs_q <= wbs_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Directed self-checking bench for assoc_cache_controller (default geometry).
module tb_assoc_cache_controller;

    logic         clk;
    logic         rst_n;
    logic         cpu_req_valid;
    logic         cpu_req_rw;
    logic [31:0]  cpu_req_addr;
    logic [31:0]  cpu_req_wdata;
    logic         cpu_req_ready;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_rdata;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_wbs;
`endif

    int compared   = 0;
    int mismatched = 0;

    assoc_cache_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses),
        .stat_wbs       (stat_wbs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; returns #1 after the accepting edge.
    task automatic cpu_issue(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!cpu_req_ready && n < 50) begin
            step();
            n++;
        end
        check("req_ready", cpu_req_ready, 1'b1);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        step();
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!mem_req_valid && n < 50) begin
            step();
            n++;
        end
        check(tag, mem_req_valid, 1'b1);
    endtask

    task automatic mem_handshake();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
    endtask

    task automatic mem_return(input logic [127:0] line);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = line;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (!cpu_resp_valid && n < 50) begin
            step();
            n++;
        end
        check(tag, cpu_resp_valid, 1'b1);
    endtask

    initial begin
        rst_n          = 1'b0;
        cpu_req_valid  = 1'b0;
        cpu_req_rw     = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_wdata  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        #12;
        check("rst_ready", cpu_req_ready, 1'b1);
        check("rst_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_resp_rdata", cpu_resp_rdata, 32'h0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_mem_rw", mem_req_rw, 1'b0);
        check("rst_mem_addr", mem_req_addr, 32'h0);
        check("rst_mem_wdata", mem_req_wdata, 128'h0);
        rst_n = 1'b1;
        step();

        // 1: write miss into empty set, fetch then merge
        cpu_issue(1'b1, 32'h0000_AB04, 32'h1122_3344);
        check("s1_compare_no_mem", mem_req_valid, 1'b0);
        wait_mem_req("s1_fetch_seen");
        check("s1_fetch_rw", mem_req_rw, 1'b0);
        check("s1_fetch_addr", mem_req_addr, 32'h0000_AB00);
        mem_handshake();
        check("s1_refill_no_mem", mem_req_valid, 1'b0);
        mem_return(128'h0);
        check("s1_resp_not_yet", cpu_resp_valid, 1'b0);
        wait_resp("s1_resp");

        // 2: read hit, response in second cycle after accept
        step();
        cpu_issue(1'b0, 32'h0000_AB04, 32'h0);
        check("s2_c1_resp", cpu_resp_valid, 1'b0);
        check("s2_c1_mem", mem_req_valid, 1'b0);
        step();
        check("s2_c2_resp", cpu_resp_valid, 1'b1);
        check("s2_c2_rdata", cpu_resp_rdata, 32'h1122_3344);
        check("s2_c2_mem", mem_req_valid, 1'b0);
        step();
        check("s2_strobe_one_cycle", cpu_resp_valid, 1'b0);

        // 3: conflicting tag fills way1 without writeback; stray resp during handshake ignored
        cpu_issue(1'b0, 32'h0000_EB00, 32'h0);
        wait_mem_req("s3_fetch_seen");
        check("s3_fetch_rw", mem_req_rw, 1'b0);
        check("s3_fetch_addr", mem_req_addr, 32'h0000_EB00);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 128'hDEAD_BEEF;
        mem_handshake();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        step();
        check("s3_refill_wait", cpu_resp_valid, 1'b0);
        mem_return(128'h5566);
        wait_resp("s3_resp");
        check("s3_rdata", cpu_resp_rdata, 32'h0000_5566);

        // 4: set full; LRU way0 is dirty and gets written back, with ready stalled
        step();
        cpu_issue(1'b0, 32'h0001_AB00, 32'h0);
        wait_mem_req("s4_wb_seen");
        for (int i = 0; i < 5; i++) begin
            check("s4_wb_rw", mem_req_rw, 1'b1);
            check("s4_wb_addr", mem_req_addr, 32'h0000_AB00);
            check("s4_wb_wdata", mem_req_wdata, {64'h0, 32'h1122_3344, 32'h0});
            step();
        end
        check("s4_wb_held", mem_req_valid, 1'b1);
        mem_handshake();
        check("s4_fetch_valid", mem_req_valid, 1'b1);
        check("s4_fetch_rw", mem_req_rw, 1'b0);
        check("s4_fetch_addr", mem_req_addr, 32'h0001_AB00);
        mem_handshake();
        check("s4_refill_no_mem", mem_req_valid, 1'b0);
`ifdef CACHE_STATS_EN
        check("stat_hits", stat_hits, 32'd1);
        check("stat_misses", stat_misses, 32'd3);
        check("stat_wbs", stat_wbs, 32'd1);
`endif

        // 5: asynchronous reset in REFILL aborts; cache contents are invalidated
        rst_n = 1'b0;
        #1;
        check("abort_mem_valid", mem_req_valid, 1'b0);
        check("abort_ready", cpu_req_ready, 1'b1);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_resp", cpu_resp_valid, 1'b0);
        cpu_issue(1'b0, 32'h0000_EB00, 32'h0);
        check("s5_compare_no_mem", mem_req_valid, 1'b0);
        wait_mem_req("s5_fetch_seen");
        check("s5_fetch_rw", mem_req_rw, 1'b0);
        check("s5_fetch_addr", mem_req_addr, 32'h0000_EB00);
        mem_handshake();
        mem_return({96'h0, 32'hCAFE_0001});
        wait_resp("s5_resp");
        check("s5_rdata", cpu_resp_rdata, 32'hCAFE_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
